// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: 8N1-style framing from a dataok/txdata byte stream.
// One-byte holding register lets frames run back-to-back with no idle gap.
module uart_tx_serializer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_uart,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] txdata,
  input  logic                 dataok,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 overrun
);

  localparam int STOP_TICKS = OVERSAMPLE * STOP_BITS;
  localparam int TW = (STOP_TICKS > 1) ? $clog2(STOP_TICKS) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t               state, state_n;
  logic [TW-1:0]        tick, tick_n;
  logic [BW-1:0]        bitc, bit_n;
  logic [DATA_BITS-1:0] shifter, shift_n;
  logic [DATA_BITS-1:0] hold, hold_n;
  logic                 hold_valid, hv_n;
  logic                 dataok_d;
  logic                 req;
  logic                 consume;
  logic                 txd_n;
  logic                 ovr_n;

  assign req = dataok & ~dataok_d;

  // txd_n is the line level for the state being entered, so txd stays registered
  always_comb begin
    state_n = state;
    tick_n  = tick;
    bit_n   = bitc;
    shift_n = shifter;
    txd_n   = txd;
    consume = 1'b0;
    unique case (state)
      S_IDLE: begin
        txd_n = 1'b1;
        if (hold_valid) begin
          consume = 1'b1;
          shift_n = hold;
          tick_n  = '0;
          state_n = S_START;
          txd_n   = 1'b0;
        end
      end
      S_START: begin
        txd_n = 1'b0;
        if (tick == BIT_LAST) begin
          tick_n  = '0;
          bit_n   = '0;
          state_n = S_DATA;
          txd_n   = shifter[0];
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      S_DATA: begin
        txd_n = shifter[0];
        if (tick == BIT_LAST) begin
          tick_n  = '0;
          shift_n = shifter >> 1;
          if (bitc == DATA_LAST) begin
            state_n = S_STOP;
            txd_n   = 1'b1;
          end else begin
            bit_n = bitc + 1'b1;
            txd_n = shifter[1];
          end
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      S_STOP: begin
        txd_n = 1'b1;
        if (tick == STOP_LAST) begin
          tick_n = '0;
          if (hold_valid) begin
            consume = 1'b1;
            shift_n = hold;
            state_n = S_START;
            txd_n   = 1'b0;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        tick_n  = '0;
        txd_n   = 1'b1;
      end
    endcase
  end

  // a request landing on the consume cycle refills the hold rather than overrunning
  always_comb begin
    hold_n = hold;
    hv_n   = hold_valid;
    ovr_n  = 1'b0;
    if (consume) begin
      hv_n = req;
      if (req) hold_n = txdata;
    end else if (req && !hold_valid) begin
      hold_n = txdata;
      hv_n   = 1'b1;
    end else if (req) begin
      ovr_n = 1'b1;
    end
  end

  always_ff @(posedge clk_uart) begin
    if (reset) begin
      state      <= S_IDLE;
      tick       <= '0;
      bitc       <= '0;
      shifter    <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      dataok_d   <= 1'b1;
      txd        <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      tick       <= tick_n;
      bitc       <= bit_n;
      shifter    <= shift_n;
      hold       <= hold_n;
      hold_valid <= hv_n;
      dataok_d   <= dataok;
      txd        <= txd_n;
      busy       <= (state_n != S_IDLE) | hv_n;
      tx_done    <= (state_n == S_STOP) && (tick_n == STOP_LAST);
      overrun    <= ovr_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: vector table plus timed corner sequences.
// A line monitor decodes frames and checks them against an expected-byte queue.
module tb_uart_tx_serializer;

  logic       clk_uart = 1'b0;
  logic       reset;
  logic [7:0] txdata;
  logic       dataok;
  logic       txd;
  logic       busy;
  logic       tx_done;
  logic       overrun;

  int total = 0;
  int bad   = 0;
  int frames = 0;
  int done_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    int         width;
    int         exp_frames;
    int         exp_ovr;
  } vec_t;

  vec_t vecs[6];

  uart_tx_serializer dut (
    .clk_uart(clk_uart),
    .reset(reset),
    .txdata(txdata),
    .dataok(dataok),
    .txd(txd),
    .busy(busy),
    .tx_done(tx_done),
    .overrun(overrun)
  );

  always #5 clk_uart = ~clk_uart;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_uart);
    #1;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < lim);
    chk("idle_timeout", busy, 0);
  endtask

  // Samples mid-bit on falling edges; reset aborts a partially received frame.
  task automatic monitor();
    int         cnt;
    int         k;
    logic       act;
    logic [7:0] sh;
    logic [7:0] e;
    act = 1'b0;
    cnt = 0;
    sh  = '0;
    forever begin
      @(negedge clk_uart);
      if (tx_done) done_cnt++;
      if (overrun) ovr_cnt++;
      if (reset) begin
        act = 1'b0;
      end else if (!act) begin
        if (!txd) begin
          act = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt % 16 == 8) begin
          k = cnt / 16;
          if (k == 0) begin
            chk("start_bit", txd, 0);
          end else if (k <= 8) begin
            sh = {txd, sh[7:1]};
          end else begin
            chk("stop_bit", txd, 1);
            frames++;
            act = 1'b0;
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL frame_byte: got 0x%0h want none", sh);
            end else begin
              e = exp_q.pop_front();
              chk("frame_byte", sh, e);
            end
          end
        end
      end
    end
  endtask

  initial begin
    int f0;
    int o0;
    int n;
    int t1;
    int t2;
    int drop;
    fork
      monitor();
    join_none

    vecs[0] = '{8'h48, 1, 1, 0};
    vecs[1] = '{8'h65, 16, 1, 0};
    vecs[2] = '{8'hA5, 3, 1, 0};
    vecs[3] = '{8'h00, 1, 1, 0};
    vecs[4] = '{8'hFF, 2, 1, 0};
    vecs[5] = '{8'h81, 40, 1, 0};

    reset  = 1'b1;
    dataok = 1'b0;
    txdata = 8'h00;
    repeat (4) tick();
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_ovr", overrun, 0);

    // dataok held high across reset release must not start a frame
    dataok = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("held_rst_busy", busy, 0);
    chk("held_rst_txd", txd, 1);
    dataok = 1'b0;
    repeat (2) tick();

    // single byte with exact latency
    txdata = 8'h48;
    dataok = 1'b1;
    exp_q.push_back(8'h48);
    tick();
    chk("e0_busy", busy, 1);
    chk("e0_txd", txd, 1);
    dataok = 1'b0;
    tick();
    chk("e1_txd", txd, 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!tx_done && n < 400);
    chk("done_latency", n, 159);
    chk("done_busy", busy, 1);
    tick();
    chk("after_done_busy", busy, 0);
    chk("after_done_pulse", tx_done, 0);

    // vector table
    for (int i = 0; i < 6; i++) begin
      f0 = frames;
      o0 = ovr_cnt;
      txdata = vecs[i].data;
      dataok = 1'b1;
      exp_q.push_back(vecs[i].data);
      repeat (vecs[i].width) tick();
      dataok = 1'b0;
      wait_idle(400);
      chk($sformatf("vec%0d_frames", i), frames - f0, vecs[i].exp_frames);
      chk($sformatf("vec%0d_ovr", i), ovr_cnt - o0, vecs[i].exp_ovr);
      chk($sformatf("vec%0d_txd", i), txd, 1);
    end

    // back-to-back: no idle gap, busy never drops
    f0 = frames;
    txdata = 8'h0D;
    dataok = 1'b1;
    exp_q.push_back(8'h0D);
    tick();
    dataok = 1'b0;
    n = 0;
    t1 = -1;
    t2 = -1;
    drop = 0;
    while (t2 < 0 && n < 800) begin
      if (n == 19) begin
        txdata = 8'h0A;
        dataok = 1'b1;
        exp_q.push_back(8'h0A);
      end
      tick();
      n++;
      if (n == 20) dataok = 1'b0;
      if (!busy) drop++;
      if (tx_done) begin
        if (t1 < 0) t1 = n;
        else t2 = n;
      end
      if (t1 > 0 && n == t1 + 1) chk("b2b_start", txd, 0);
    end
    chk("b2b_t1", t1, 160);
    chk("b2b_t2", t2, 320);
    chk("b2b_busy_drop", drop, 0);
    tick();
    chk("b2b_busy_end", busy, 0);
    chk("b2b_frames", frames - f0, 2);

    // overrun: A sending, B held, C dropped
    f0 = frames;
    o0 = ovr_cnt;
    txdata = 8'h11;
    dataok = 1'b1;
    exp_q.push_back(8'h11);
    tick();
    dataok = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      if (k == 10) begin
        txdata = 8'h22;
        dataok = 1'b1;
        exp_q.push_back(8'h22);
      end
      if (k == 30) begin
        txdata = 8'h33;
        dataok = 1'b1;
      end
      tick();
      if (k == 10 || k == 30) dataok = 1'b0;
      if (k == 10) chk("ovr_B_none", overrun, 0);
      if (k == 30) chk("ovr_at_C", overrun, 1);
    end
    wait_idle(800);
    chk("ovr_count", ovr_cnt - o0, 1);
    chk("ovr_frames", frames - f0, 2);

    // request on the exact cycle the held byte is consumed
    f0 = frames;
    o0 = ovr_cnt;
    txdata = 8'h5A;
    dataok = 1'b1;
    exp_q.push_back(8'h5A);
    tick();
    dataok = 1'b0;
    n = 0;
    while (!tx_done && n < 400) begin
      if (n == 9) begin
        txdata = 8'hC3;
        dataok = 1'b1;
        exp_q.push_back(8'hC3);
      end
      tick();
      n++;
      if (n == 10) dataok = 1'b0;
    end
    chk("sim_done_at", n, 160);
    txdata = 8'h3C;
    dataok = 1'b1;
    exp_q.push_back(8'h3C);
    tick();
    dataok = 1'b0;
    chk("sim_no_ovr", overrun, 0);
    chk("sim_start", txd, 0);
    wait_idle(1000);
    chk("sim_ovr_count", ovr_cnt - o0, 0);
    chk("sim_frames", frames - f0, 3);

    // reset during data bit 3
    f0 = frames;
    txdata = 8'h96;
    dataok = 1'b1;
    tick();
    dataok = 1'b0;
    repeat (69) tick();
    chk("mid_busy_pre", busy, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_txd", txd, 1);
    chk("mid_rst_busy", busy, 0);
    reset = 1'b0;
    repeat (3) tick();
    chk("mid_idle_txd", txd, 1);
    txdata = 8'h5C;
    dataok = 1'b1;
    exp_q.push_back(8'h5C);
    tick();
    dataok = 1'b0;
    wait_idle(400);
    chk("mid_frames", frames - f0, 1);

    repeat (4) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
